// File: rtl/reg_bank_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin register-bank write arbiter.
package reg_bank_rr_arbiter_pkg;

  localparam int GCNT_W = 8;

  // Ceil-log2 with a floor of 1 so that single-entry ranges still get an index bit.
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Index-to-one-hot decoder covering up to 16 targets; callers size-cast the result.
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_bank_rr_arbiter_if.sv
// Requester/bank bus of the arbiter: requests in, grant and bank write strobes out.
interface reg_bank_rr_arbiter_if #(
  parameter int N       = 4,
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4
);
  import reg_bank_rr_arbiter_pkg::*;

  localparam int ADDR_W = clog2(DEPTH);

  logic                        hold;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*N-1:0]        req_din;
  logic [NUM_REQ-1:0]          gnt;
  logic [DEPTH-1:0]            bank_load;
  logic [N-1:0]                bank_din;
  logic                        err;
  logic [GCNT_W-1:0]           grant_cnt;

  modport master (
    output hold, req, req_addr, req_din,
    input  gnt, bank_load, bank_din, err, grant_cnt
  );

  modport slave (
    input  hold, req, req_addr, req_din,
    output gnt, bank_load, bank_din, err, grant_cnt
  );

endinterface

// File: rtl/reg_bank_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate eligibility so ptr lands at bit 0,
// take the lowest set bit, then rotate the found position back.
module reg_bank_rr_arbiter_rr_pick
  import reg_bank_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [PTR_W-1:0]   ptr,
  output logic               any_valid,
  output logic [PTR_W-1:0]   winner
);

  logic [NUM_REQ-1:0] rot;
  logic [PTR_W-1:0]   pos;

  always_comb begin
    rot       = '0;
    pos       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = elig[(i + int'(ptr)) % NUM_REQ];
    end
    // Scanning downward leaves the lowest set bit as the final assignment.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos       = PTR_W'(i);
        any_valid = 1'b1;
      end
    end
  end

  assign winner = PTR_W'((int'(pos) + int'(ptr)) % NUM_REQ);

endmodule

// File: rtl/reg_bank_rr_arbiter.sv
// Round-robin write arbiter driving registered one-hot load strobes and a shared
// data bus into a bank of DEPTH registers on behalf of NUM_REQ requesters.
module reg_bank_rr_arbiter
  import reg_bank_rr_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  reg_bank_rr_arbiter_if.slave  bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int PTR_W  = clog2(NUM_REQ);

  logic [NUM_REQ-1:0] elig;
  logic               any_valid;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   ptr_next;
  logic [ADDR_W-1:0]  win_addr;
  logic [N-1:0]       win_din;
  logic               addr_ok;
  logic               fire;

  logic [NUM_REQ-1:0] gnt_p1;
  logic [DEPTH-1:0]   load_p1;
  logic [N-1:0]       din_p1;
  logic               err_p1;
  logic [GCNT_W-1:0]  cnt_p1;
  logic [PTR_W-1:0]   ptr_p1;

  // Stage p0: a requester granted last edge still shows req, so it is masked out.
  assign elig = bus.req & ~gnt_p1;

  reg_bank_rr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .elig      (elig),
    .ptr       (ptr_p1),
    .any_valid (any_valid),
    .winner    (winner)
  );

  assign win_addr = bus.req_addr[int'(winner)*ADDR_W +: ADDR_W];
  assign win_din  = bus.req_din[int'(winner)*N +: N];
  assign addr_ok  = int'(win_addr) < DEPTH;
  assign ptr_next = (int'(winner) == NUM_REQ - 1) ? '0 : PTR_W'(winner + 1'b1);
  assign fire     = ~bus.hold & any_valid;

  // Stage p1: registered grant, bank strobes and bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_p1  <= '0;
      load_p1 <= '0;
      din_p1  <= '0;
      err_p1  <= 1'b0;
      cnt_p1  <= '0;
      ptr_p1  <= '0;
    end else if (fire) begin
      gnt_p1  <= NUM_REQ'(onehot16(4'(winner)));
      din_p1  <= win_din;
      load_p1 <= addr_ok ? DEPTH'(onehot16(4'(win_addr))) : '0;
      err_p1  <= ~addr_ok;
      ptr_p1  <= ptr_next;
      cnt_p1  <= cnt_p1 + 1'b1;
    end else begin
      gnt_p1  <= '0;
      load_p1 <= '0;
      err_p1  <= 1'b0;
    end
  end

  assign bus.gnt       = gnt_p1;
  assign bus.bank_load = load_p1;
  assign bus.bank_din  = din_p1;
  assign bus.err       = err_p1;
  assign bus.grant_cnt = cnt_p1;

endmodule

// File: tb/tb_reg_bank_rr_arbiter.sv
// Bench for reg_bank_rr_arbiter: vector table, directed corner sequences and
// randomized traffic checked against a behavioural arbitration model.
module tb_reg_bank_rr_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reg_bank_rr_arbiter_if #(.N(4), .NUM_REQ(4), .DEPTH(4)) bus_a ();
  reg_bank_rr_arbiter_if #(.N(4), .NUM_REQ(4), .DEPTH(3)) bus_b ();

  reg_bank_rr_arbiter #(.N(4), .NUM_REQ(4), .DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );
  reg_bank_rr_arbiter #(.N(4), .NUM_REQ(4), .DEPTH(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Bank registers fed by dut_a's strobes.
  logic [3:0] bank_a [4];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) bank_a[k] <= 4'h0;
    end else begin
      for (int k = 0; k < 4; k++) if (bus_a.bank_load[k]) bank_a[k] <= bus_a.bank_din;
    end
  end

  // Reference model state for dut_a (DEPTH=4, NUM_REQ=4).
  logic [3:0] m_gnt, m_load, m_din;
  logic       m_err;
  int         m_ptr, m_cnt;

  task automatic model_reset();
    m_gnt = 0; m_load = 0; m_din = 0; m_err = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [3:0] elig;
    int w;
    int a;
    elig = bus_a.req & ~m_gnt;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      if (w < 0 && elig[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    end
    if (!bus_a.hold && w >= 0) begin
      m_gnt = 4'(1 << w);
      m_din = bus_a.req_din[w*4 +: 4];
      a = int'(bus_a.req_addr[w*2 +: 2]);
      if (a < 4) begin m_load = 4'(1 << a); m_err = 0; end
      else begin m_load = 0; m_err = 1; end
      m_ptr = (w + 1) % 4;
      m_cnt = (m_cnt + 1) % 256;
    end else begin
      m_gnt = 0; m_load = 0; m_err = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("gnt", 32'(bus_a.gnt), 32'(m_gnt));
    check("bank_load", 32'(bus_a.bank_load), 32'(m_load));
    check("bank_din", 32'(bus_a.bank_din), 32'(m_din));
    check("err", 32'(bus_a.err), 32'(m_err));
    check("grant_cnt", 32'(bus_a.grant_cnt), 32'(m_cnt));
  endtask

  typedef struct {
    logic       hold;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] load;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001};
    tbl[1]  = '{1'b0, 4'b1111, 4'b0010, 4'b0010};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0100, 4'b0100};
    tbl[3]  = '{1'b0, 4'b1111, 4'b1000, 4'b1000};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[6]  = '{1'b0, 4'b0010, 4'b0010, 4'b0010};
    tbl[7]  = '{1'b1, 4'b1010, 4'b0000, 4'b0000};
    tbl[8]  = '{1'b1, 4'b1010, 4'b0000, 4'b0000};
    tbl[9]  = '{1'b1, 4'b1010, 4'b0000, 4'b0000};
    tbl[10] = '{1'b0, 4'b1010, 4'b1000, 4'b1000};
    tbl[11] = '{1'b0, 4'b1010, 4'b0010, 4'b0010};

    bus_a.hold = 1'b0;
    bus_a.req = 4'b1111;
    bus_a.req_addr = 8'b11_10_01_00;
    bus_a.req_din = 16'h8765;
    bus_b.hold = 1'b0;
    bus_b.req = 4'b0000;
    bus_b.req_addr = 8'h00;
    bus_b.req_din = 16'h0000;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(bus_a.gnt), 0);
    check("rst_load", 32'(bus_a.bank_load), 0);
    check("rst_din", 32'(bus_a.bank_din), 0);
    check("rst_err", 32'(bus_a.err), 0);
    check("rst_cnt", 32'(bus_a.grant_cnt), 0);
    check("rst_b_gnt", 32'(bus_b.gnt), 0);
    check("rst_b_cnt", 32'(bus_b.grant_cnt), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      bus_a.hold = tbl[i].hold;
      bus_a.req  = tbl[i].req;
      tick();
      check($sformatf("tbl%0d_gnt", i), 32'(bus_a.gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_load", i), 32'(bus_a.bank_load), 32'(tbl[i].load));
      if (i == 4) check("tbl_cnt5", 32'(bus_a.grant_cnt), 5);
    end

    // Single requester: granted every other cycle, writes 0xA into register 3.
    bus_a.req = 4'b0100;
    bus_a.req_addr[5:4] = 2'd3;
    bus_a.req_din[11:8] = 4'hA;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("solo%0d_gnt", k), 32'(bus_a.gnt), (k % 2 == 0) ? 32'b0100 : 32'b0);
      check($sformatf("solo%0d_load", k), 32'(bus_a.bank_load), (k % 2 == 0) ? 32'b1000 : 32'b0);
    end
    check("solo_bank3", 32'(bank_a[3]), 32'hA);
    bus_a.req = 4'b0000;
    bus_a.req_addr[5:4] = 2'd2;

    // Out-of-range address on the DEPTH=3 instance.
    bus_b.req_addr = 8'h0C;
    bus_b.req_din = 16'h00C0;
    bus_b.req = 4'b0010;
    tick();
    check("b_err_gnt", 32'(bus_b.gnt), 32'b0010);
    check("b_err_load", 32'(bus_b.bank_load), 0);
    check("b_err_err", 32'(bus_b.err), 1);
    check("b_err_cnt", 32'(bus_b.grant_cnt), 1);
    check("b_err_din", 32'(bus_b.bank_din), 32'hC);
    bus_b.req = 4'b0000;
    tick();
    check("b_err_pulse", 32'(bus_b.err), 0);
    check("b_idle_gnt", 32'(bus_b.gnt), 0);
    bus_b.req = 4'b0110;
    tick();
    check("b_ptr2_gnt", 32'(bus_b.gnt), 32'b0100);
    check("b_ptr2_load", 32'(bus_b.bank_load), 32'b001);
    check("b_ptr2_err", 32'(bus_b.err), 0);
    check("b_ptr2_cnt", 32'(bus_b.grant_cnt), 2);
    bus_b.req = 4'b0000;

    // Asynchronous reset landing on a live grant.
    bus_a.req = 4'b0100;
    tick();
    check("mid_pre_gnt", 32'(bus_a.gnt), 32'b0100);
    reset_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(bus_a.gnt), 0);
    check("mid_rst_load", 32'(bus_a.bank_load), 0);
    check("mid_rst_err", 32'(bus_a.err), 0);
    check("mid_rst_cnt", 32'(bus_a.grant_cnt), 0);
    model_reset();
    @(posedge clk);
    #1;
    check("mid_hold_gnt", 32'(bus_a.gnt), 0);
    reset_n = 1'b1;
    tick();
    check("mid_reissue_gnt", 32'(bus_a.gnt), 32'b0100);
    check("mid_reissue_cnt", 32'(bus_a.grant_cnt), 1);

    // Counter wrap under full load.
    bus_a.req = 4'b1111;
    for (int g = 0; g < 400 && m_cnt != 255; g++) tick();
    check("wrap_pre", 32'(bus_a.grant_cnt), 255);
    tick();
    check("wrap_cnt", 32'(bus_a.grant_cnt), 0);
    tick();
    check("wrap_after", 32'(bus_a.grant_cnt), 1);

    // Randomized traffic against the model.
    for (int r = 0; r < 300; r++) begin
      bus_a.hold     = ($urandom_range(0, 4) == 0);
      bus_a.req      = 4'($urandom);
      bus_a.req_addr = 8'($urandom);
      bus_a.req_din  = 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_rr_arbiter.md
Name: reg_bank_rr_arbiter

Overview:
- Round-robin write arbiter sharing a bank of DEPTH N-bit load registers (synchronous load, async active-low reset) among NUM_REQ requesters.
- Each requester presents req/addr/din. The arbiter grants one requester per cycle and drives registered one-hot load strobes plus a shared data bus to the bank.
- Sits between requester logic and the register bank; it owns the bank's load and din inputs.

Parameters:
- N, 4, data width of each bank register.
- NUM_REQ, 4, number of requesters (2..8).
- DEPTH, 4, number of bank registers (1..16, need not be a power of 2).
- ADDR_W, clog2(DEPTH) (min 1), derived localparam; never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- hold  in  1  1 = freeze arbitration; no new grants.
- req  in  NUM_REQ  per-requester write request, level; held until grant seen.
- req_addr  in  NUM_REQ*ADDR_W  flattened target addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_din  in  NUM_REQ*N  flattened write data; requester i at [i*N +: N].
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse, registered.
- bank_load  out  DEPTH  one-hot load strobe to the bank, registered.
- bank_din  out  N  data to all bank registers, registered.
- err  out  1  one-cycle pulse: granted request had addr >= DEPTH.
- grant_cnt  out  8  count of grants issued, wraps 255->0.

Behaviour:
- Reset (async, reset_n=0): gnt=0, bank_load=0, bank_din=0, err=0, grant_cnt=0, round-robin pointer ptr=0. Reset mid-operation aborts any pending grant; no partial load is emitted after release.
- Eligible set each cycle: elig = req & ~gnt. A requester being granted this cycle is masked, because its req is still high for one cycle after the edge.
- Arbitration is combinational from elig and ptr. The winner is the first set bit of elig searching i = ptr, ptr+1, ..., wrapping NUM_REQ-1 -> 0.
- At each rising edge, if hold=0 and elig != 0:
  - gnt <= onehot(winner).
  - bank_din <= req_din[winner].
  - If req_addr[winner] < DEPTH: bank_load <= onehot(addr), err <= 0. Otherwise bank_load <= 0, err <= 1.
  - ptr <= (winner+1) mod NUM_REQ.
  - grant_cnt <= grant_cnt+1.
- Otherwise: gnt, bank_load and err are set to 0. bank_din, ptr and grant_cnt hold.
- Latency: req sampled at edge T -> gnt and bank_load high during cycle T..T+1 -> bank register captures bank_din at edge T+1.
- Handshake: a requester deasserts req, or changes addr/din for its next request, in the cycle it sees gnt=1.
- Throughput: different requesters can be granted on consecutive cycles. A single requester is granted at most every other cycle.
- hold=1 does not cancel a grant already registered; that pulse completes normally.
- Outputs are mutually consistent: popcount(gnt) <= 1, popcount(bank_load) <= 1, and bank_load != 0 implies gnt != 0.
- A change to req while not granted is fine. Requests are not queued; req is re-sampled every cycle.

Decomposition:
- Shared package/header holds:
  - the clog2 function for ADDR_W;
  - the onehot-decode helper;
  - the grant_cnt width constant (8).
- One sub-module, rr_pick:
  - combinational;
  - inputs elig[NUM_REQ] and ptr;
  - outputs any_valid and winner index;
  - implemented as a rotate, priority-encode, un-rotate.
- The top level holds the ptr register, the output registers and the counter.

Test Plan:
- Reset with req=4'b1111 held, then release reset_n: first gnt=4'b0001 one cycle after release, then 0010, 0100, 1000, 0001 on consecutive cycles. grant_cnt reaches 5.
- Only req[2]=1 held continuously, addr=3, din=4'hA: gnt=0100 on alternate cycles. Each grant pulses bank_load=4'b1000 with bank_din=4'hA. A bank model captures 4'hA in register 3.
- DEPTH=3, req[1]=1 with addr=3: gnt=0010, bank_load=000, err=1 for one cycle. ptr advances to 2 and grant_cnt increments.
- req=4'b1010 with ptr=2 and hold asserted for 3 cycles: no gnt during hold. On hold release the next grant is 1000, then 0010.
- Assert reset_n=0 in the cycle gnt=0100: gnt, bank_load, err and grant_cnt go to 0 immediately, asynchronously. After release with req=0100 still high, the grant is reissued with ptr=0 ordering.
- 256 grants: grant_cnt wraps 255 -> 0 with no change to arbitration order.
